// File: rtl/pulse_meter.sv
// Measures the high time, low time and period of an asynchronous waveform in clock
// cycles, and reports each completed period with a one-cycle valid strobe.
module pulse_meter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal_in,
    output logic [WIDTH-1:0] high_len,
    output logic [WIDTH-1:0] low_len,
    output logic [WIDTH:0]   period_len,
    output logic             valid,
    output logic             overflow,
    output logic [WIDTH-1:0] pulse_count
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state, state_next;
    logic             s1, s2, s3;
    logic [1:0]       fill;
    logic [WIDTH-1:0] hcnt, lcnt, hcnt_next, lcnt_next;
    logic             rise, fall, report, sat_hit;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_comb begin
        state_next = state;
        hcnt_next  = hcnt;
        lcnt_next  = lcnt;
        report     = 1'b0;
        sat_hit    = 1'b0;
        case (state)
            // s2 is only trusted once real samples have reached it; the zeroed
            // synchronizer must not pose as a low level at reset release.
            IDLE: begin
                if (fill[1] && !s2) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    state_next = MEAS_HIGH;
                    hcnt_next  = CNT_ONE;
                end
            end
            MEAS_HIGH: begin
                if (s2) begin
                    if (hcnt == CNT_MAX) begin
                        sat_hit = 1'b1;
                    end else begin
                        hcnt_next = hcnt + 1'b1;
                    end
                end else if (fall) begin
                    state_next = MEAS_LOW;
                    lcnt_next  = CNT_ONE;
                end
            end
            MEAS_LOW: begin
                if (!s2) begin
                    if (lcnt == CNT_MAX) begin
                        sat_hit = 1'b1;
                    end else begin
                        lcnt_next = lcnt + 1'b1;
                    end
                end else if (rise) begin
                    state_next = MEAS_HIGH;
                    hcnt_next  = CNT_ONE;
                    report     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            fill        <= '0;
            state       <= IDLE;
            hcnt        <= '0;
            lcnt        <= '0;
            high_len    <= '0;
            low_len     <= '0;
            period_len  <= '0;
            pulse_count <= '0;
            valid       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            s1    <= signal_in;
            s2    <= s1;
            s3    <= s2;
            fill  <= {fill[0], 1'b1};
            state <= state_next;
            hcnt  <= hcnt_next;
            lcnt  <= lcnt_next;
            valid <= report;
            if (sat_hit) begin
                overflow <= 1'b1;
            end
            if (report) begin
                high_len    <= hcnt;
                low_len     <= lcnt;
                period_len  <= {1'b0, hcnt} + {1'b0, lcnt};
                pulse_count <= pulse_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: WIDTH=8 and WIDTH=4 instances share one stimulus and are
// checked every cycle against a run-length model of the sampled waveform.
module tb_pulse_meter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       signal_in = 1'b0;
    logic [7:0] high8, low8, cnt8;
    logic [8:0] per8;
    logic       valid8, ovf8;
    logic [3:0] high4, low4, cnt4;
    logic [4:0] per4;
    logic       valid4, ovf4;
    logic [34:0] obs8;
    logic [18:0] obs4;
    int checks = 0;
    int failures = 0;

    pulse_meter #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .signal_in(signal_in),
        .high_len(high8), .low_len(low8), .period_len(per8),
        .valid(valid8), .overflow(ovf8), .pulse_count(cnt8)
    );

    pulse_meter #(.WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .signal_in(signal_in),
        .high_len(high4), .low_len(low4), .period_len(per4),
        .valid(valid4), .overflow(ovf4), .pulse_count(cnt4)
    );

    always #5 clock = ~clock;

    assign obs8 = {valid8, ovf8, high8, low8, per8, cnt8};
    assign obs4 = {valid4, ovf4, high4, low4, per4, cnt4};

    // Reference model: run-length encoding of the sampled stream since reset.
    // Run 0 is never measured (no observed rise); a rise closes a period once a
    // measured high run and its following low run exist.
    int max_len[2] = '{255, 15};
    int nruns[2], cur_len[2], prev_len[2];
    bit cur_val[2];
    bit e_valid[2], e_ovf[2];
    int e_high[2], e_low[2], e_cnt[2];
    bit pipe[$];

    function automatic int sat(input int n, input int i);
        return (n > max_len[i]) ? max_len[i] : n;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            nruns[i] = 0; cur_len[i] = 0; prev_len[i] = 0; cur_val[i] = 0;
            e_valid[i] = 0; e_ovf[i] = 0; e_high[i] = 0; e_low[i] = 0; e_cnt[i] = 0;
        end
        pipe.delete();
    endfunction

    function automatic void model_feed(input int i, input bit b);
        if (nruns[i] == 0) begin
            nruns[i] = 1; cur_val[i] = b; cur_len[i] = 1;
        end else if (b == cur_val[i]) begin
            cur_len[i]++;
            if (cur_len[i] > max_len[i] && nruns[i] >= (b ? 2 : 3)) e_ovf[i] = 1;
        end else begin
            if (b && nruns[i] >= 3) begin
                e_high[i]  = sat(prev_len[i], i);
                e_low[i]   = sat(cur_len[i], i);
                e_cnt[i]   = (e_cnt[i] + 1) % (max_len[i] + 1);
                e_valid[i] = 1;
            end
            prev_len[i] = cur_len[i];
            cur_val[i]  = b;
            cur_len[i]  = 1;
            nruns[i]++;
        end
    endfunction

    function automatic logic [34:0] exp8();
        return {e_valid[0], e_ovf[0], 8'(e_high[0]), 8'(e_low[0]),
                9'(e_high[0] + e_low[0]), 8'(e_cnt[0])};
    endfunction

    function automatic logic [18:0] exp4();
        return {e_valid[1], e_ovf[1], 4'(e_high[1]), 4'(e_low[1]),
                5'(e_high[1] + e_low[1]), 4'(e_cnt[1])};
    endfunction

    // One clock: drive at negedge (optionally with a sub-cycle glitch), advance the
    // model by the sample that has just reached the second synchronizer stage.
    task automatic step(input logic v, input bit glitch = 1'b0);
        bit b;
        @(negedge clock);
        signal_in = v;
        if (glitch) begin
            #2 signal_in = ~v;
            #1 signal_in = v;
        end
        @(posedge clock);
        e_valid[0] = 0;
        e_valid[1] = 0;
        if (!reset) begin
            model_clear();
        end else begin
            pipe.push_back(v);
            if (pipe.size() > 2) begin
                b = pipe.pop_front();
                model_feed(0, b);
                model_feed(1, b);
            end
        end
        #1;
    endtask

    task automatic apply_reset(input logic v);
        reset = 1'b0;
        step(v);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        apply_reset(1'($urandom_range(0, 1)));
        checks += 2;
        if (obs8 !== '0) begin failures++; $display("FAIL reset_w8 got=%h exp=0", obs8); end
        if (obs4 !== '0) begin failures++; $display("FAIL reset_w4 got=%h exp=0", obs4); end
    endtask

    task automatic test_square();
        bit seq[$];
        int nv = 0;
        int last = -1;
        apply_reset(1'b0);
        repeat (3) seq.push_back(0);
        repeat (5) begin
            repeat (4) seq.push_back(1);
            repeat (4) seq.push_back(0);
        end
        repeat (3) seq.push_back(0);
        foreach (seq[k]) begin
            step(seq[k]);
            checks += 2;
            if (obs8 !== exp8()) begin failures++; $display("FAIL square_w8 k=%0d got=%h exp=%h", k, obs8, exp8()); end
            if (obs4 !== exp4()) begin failures++; $display("FAIL square_w4 k=%0d got=%h exp=%h", k, obs4, exp4()); end
            if (valid8) begin
                nv++;
                checks++;
                if ({high8, low8, per8, cnt8, ovf8} !== {8'd4, 8'd4, 9'd8, 8'(nv), 1'b0}) begin
                    failures++;
                    $display("FAIL square_values got=%0d/%0d/%0d cnt=%0d ovf=%b exp=4/4/8 cnt=%0d ovf=0",
                             high8, low8, per8, cnt8, ovf8, nv);
                end
                if (last >= 0) begin
                    checks++;
                    if (k - last != 8) begin failures++; $display("FAIL square_spacing got=%0d exp=8", k - last); end
                end
                last = k;
            end
        end
        checks++;
        if (nv != 4) begin failures++; $display("FAIL square_strobes got=%0d exp=4", nv); end
    endtask

    task automatic test_duty();
        bit seq[$];
        int exp_pairs[8] = '{3, 5, 3, 5, 6, 2, 6, 2};
        int nv = 0;
        logic prev_valid = 1'b0;
        apply_reset(1'b0);
        repeat (2) seq.push_back(0);
        repeat (2) begin repeat (3) seq.push_back(1); repeat (5) seq.push_back(0); end
        repeat (2) begin repeat (6) seq.push_back(1); repeat (2) seq.push_back(0); end
        repeat (3) seq.push_back(1);
        foreach (seq[k]) begin
            step(seq[k]);
            checks += 3;
            if (obs8 !== exp8()) begin failures++; $display("FAIL duty_w8 k=%0d got=%h exp=%h", k, obs8, exp8()); end
            if (obs4 !== exp4()) begin failures++; $display("FAIL duty_w4 k=%0d got=%h exp=%h", k, obs4, exp4()); end
            if (valid8 && prev_valid) begin failures++; $display("FAIL duty_strobe_width got=2 exp=1"); end
            prev_valid = valid8;
            if (valid8 && nv < 4) begin
                checks++;
                if ({high8, low8, per8} !== {8'(exp_pairs[2*nv]), 8'(exp_pairs[2*nv+1]), 9'd8}) begin
                    failures++;
                    $display("FAIL duty_values n=%0d got=%0d/%0d/%0d exp=%0d/%0d/8",
                             nv, high8, low8, per8, exp_pairs[2*nv], exp_pairs[2*nv+1]);
                end
                nv++;
            end
        end
        checks++;
        if (nv != 4) begin failures++; $display("FAIL duty_strobes got=%0d exp=4", nv); end
    endtask

    task automatic test_high_at_release();
        bit seq[$];
        int first = -1;
        apply_reset(1'b1);
        repeat (10) seq.push_back(1);
        repeat (4) begin seq.push_back(0); seq.push_back(0); seq.push_back(1); seq.push_back(1); end
        seq.push_back(0);
        seq.push_back(0);
        foreach (seq[k]) begin
            step(seq[k]);
            checks += 2;
            if (obs8 !== exp8()) begin failures++; $display("FAIL release_w8 k=%0d got=%h exp=%h", k, obs8, exp8()); end
            if (obs4 !== exp4()) begin failures++; $display("FAIL release_w4 k=%0d got=%h exp=%h", k, obs4, exp4()); end
            if (valid8 && first < 0) begin
                first = k;
                checks++;
                if ({high8, low8, per8, cnt8} !== {8'd2, 8'd2, 9'd4, 8'd1}) begin
                    failures++;
                    $display("FAIL release_first got=%0d/%0d/%0d cnt=%0d exp=2/2/4 cnt=1", high8, low8, per8, cnt8);
                end
            end
        end
        checks++;
        if (first != 18) begin failures++; $display("FAIL release_latency got=%0d exp=18", first); end
    endtask

    task automatic test_saturate();
        bit seq[$];
        int nv = 0;
        apply_reset(1'b0);
        repeat (2) seq.push_back(0);
        repeat (20) seq.push_back(1);
        repeat (3) seq.push_back(0);
        repeat (3) begin seq.push_back(1); seq.push_back(1); seq.push_back(0); seq.push_back(0); end
        repeat (3) seq.push_back(1);
        foreach (seq[k]) begin
            step(seq[k]);
            checks += 2;
            if (obs8 !== exp8()) begin failures++; $display("FAIL sat_w8 k=%0d got=%h exp=%h", k, obs8, exp8()); end
            if (obs4 !== exp4()) begin failures++; $display("FAIL sat_w4 k=%0d got=%h exp=%h", k, obs4, exp4()); end
            if (nv > 0) begin
                checks++;
                if (ovf4 !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%b exp=1", ovf4); end
            end
            if (valid4) begin
                if (nv == 0) begin
                    checks += 2;
                    if ({high4, low4, per4, ovf4} !== {4'd15, 4'd3, 5'd18, 1'b1}) begin
                        failures++;
                        $display("FAIL sat_first_w4 got=%0d/%0d/%0d ovf=%b exp=15/3/18 ovf=1", high4, low4, per4, ovf4);
                    end
                    if ({high8, low8, per8, ovf8} !== {8'd20, 8'd3, 9'd23, 1'b0}) begin
                        failures++;
                        $display("FAIL sat_first_w8 got=%0d/%0d/%0d ovf=%b exp=20/3/23 ovf=0", high8, low8, per8, ovf8);
                    end
                end
                nv++;
            end
        end
        checks++;
        if (nv != 4) begin failures++; $display("FAIL sat_strobes got=%0d exp=4", nv); end
    endtask

    task automatic test_reset_mid();
        bit seq[$];
        int nv = 0;
        apply_reset(1'b0);
        repeat (2) seq.push_back(0);
        repeat (4) seq.push_back(1);
        repeat (3) seq.push_back(0);
        repeat (5) seq.push_back(1);
        foreach (seq[k]) begin
            step(seq[k]);
            checks += 2;
            if (obs8 !== exp8()) begin failures++; $display("FAIL mid_pre_w8 k=%0d got=%h exp=%h", k, obs8, exp8()); end
            if (obs4 !== exp4()) begin failures++; $display("FAIL mid_pre_w4 k=%0d got=%h exp=%h", k, obs4, exp4()); end
        end
        apply_reset(1'b1);
        checks += 2;
        if (obs8 !== '0) begin failures++; $display("FAIL mid_zero_w8 got=%h exp=0", obs8); end
        if (obs4 !== '0) begin failures++; $display("FAIL mid_zero_w4 got=%h exp=0", obs4); end
        seq.delete();
        repeat (2) seq.push_back(1);
        repeat (2) seq.push_back(0);
        repeat (3) begin repeat (2) seq.push_back(1); repeat (3) seq.push_back(0); end
        repeat (3) seq.push_back(1);
        foreach (seq[k]) begin
            step(seq[k]);
            checks += 2;
            if (obs8 !== exp8()) begin failures++; $display("FAIL mid_post_w8 k=%0d got=%h exp=%h", k, obs8, exp8()); end
            if (obs4 !== exp4()) begin failures++; $display("FAIL mid_post_w4 k=%0d got=%h exp=%h", k, obs4, exp4()); end
            if (valid8 && nv == 0) begin
                checks++;
                if ({high8, low8, per8, cnt8} !== {8'd2, 8'd3, 9'd5, 8'd1}) begin
                    failures++;
                    $display("FAIL mid_first got=%0d/%0d/%0d cnt=%0d exp=2/3/5 cnt=1", high8, low8, per8, cnt8);
                end
            end
            if (valid8) nv++;
        end
        checks++;
        if (nv != 3) begin failures++; $display("FAIL mid_strobes got=%0d exp=3", nv); end
    endtask

    task automatic test_pulses();
        bit seq[$];
        int nv = 0;
        apply_reset(1'b0);
        repeat (2) seq.push_back(0);
        repeat (19) begin seq.push_back(1); seq.push_back(0); seq.push_back(0); end
        seq.push_back(1);
        seq.push_back(0);
        seq.push_back(0);
        foreach (seq[k]) begin
            step(seq[k], k % 5 == 1);
            checks += 2;
            if (obs8 !== exp8()) begin failures++; $display("FAIL pulses_w8 k=%0d got=%h exp=%h", k, obs8, exp8()); end
            if (obs4 !== exp4()) begin failures++; $display("FAIL pulses_w4 k=%0d got=%h exp=%h", k, obs4, exp4()); end
            if (valid4) begin
                nv++;
                checks++;
                if ({high4, low4, per4, cnt4, cnt8} !== {4'd1, 4'd2, 5'd3, 4'(nv % 16), 8'(nv)}) begin
                    failures++;
                    $display("FAIL pulses_values got=%0d/%0d/%0d cnt4=%0d cnt8=%0d exp=1/2/3 cnt4=%0d cnt8=%0d",
                             high4, low4, per4, cnt4, cnt8, nv % 16, nv);
                end
            end
        end
        checks++;
        if (nv != 19) begin failures++; $display("FAIL pulses_strobes got=%0d exp=19", nv); end
    endtask

    task automatic test_random();
        int   left = 0;
        logic lvl = 1'b0;
        apply_reset(1'b0);
        for (int k = 0; k < 800; k++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 199) == 0) reset = 1'b0;
            step(lvl, $urandom_range(0, 7) == 0);
            reset = 1'b1;
            left--;
            checks += 2;
            if (obs8 !== exp8()) begin failures++; $display("FAIL random_w8 k=%0d got=%h exp=%h", k, obs8, exp8()); end
            if (obs4 !== exp4()) begin failures++; $display("FAIL random_w4 k=%0d got=%h exp=%h", k, obs4, exp4()); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_square();
        test_duty();
        test_high_at_release();
        test_saturate();
        test_reset_mid();
        test_pulses();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
